// File: rtl/vga_frame_capture.sv
// VGA receive side: measures line/frame geometry and grabs one armed active frame into a framebuffer.
// Optional CAPTURE_CHECKSUM_EN builds a running 32-bit sum of written pixels on oCHECKSUM.
module vga_frame_capture #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   input  logic              iHS,
   input  logic              iVS,
   input  logic              iBLANK_n,
   input  logic [7:0]        iB,
   input  logic [7:0]        iG,
   input  logic [7:0]        iR,
   input  logic              iARM,
   output logic              oBUSY,
   output logic              oDONE,
   output logic              oERR,
   output logic              oWR_EN,
   output logic [ADDR_W-1:0] oWR_ADDR,
   output logic [23:0]       oWR_DATA,
   output logic [10:0]       oLINE_LEN,
   output logic [9:0]        oLINE_CNT,
   output logic [31:0]       oCHECKSUM
);

   localparam logic [10:0] H_LEN  = 11'(H_ACTIVE);
   localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;

   state_t state, state_next;

   logic              vs_r, vs_d, blank_r, blank_d, arm_r;
   logic [23:0]       pix_r;
   logic [10:0]       x;
   logic [9:0]        line_cnt, line_cnt_inc;
   logic [ADDR_W-1:0] addr;
   logic              frame_start, line_end, last_line;
   logic              write_hit, err_hit, arm_clear;
   logic              unused_hs;

   // HS carries no information the blank/vsync edges do not already give
   assign unused_hs = iHS;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         vs_r    <= 1'b0;
         vs_d    <= 1'b0;
         blank_r <= 1'b0;
         blank_d <= 1'b0;
         arm_r   <= 1'b0;
         pix_r   <= '0;
      end else begin
         vs_r    <= iVS;
         vs_d    <= vs_r;
         blank_r <= iBLANK_n;
         blank_d <= blank_r;
         arm_r   <= iARM;
         pix_r   <= {iB, iG, iR};
      end
   end

   assign frame_start  = vs_d & ~vs_r;
   assign line_end     = blank_d & ~blank_r;
   assign line_cnt_inc = (line_cnt == '1) ? line_cnt : line_cnt + 10'd1;
   assign last_line    = line_end && (x == H_LEN) && (line_cnt == V_LAST);

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         x         <= '0;
         line_cnt  <= '0;
         oLINE_LEN <= '0;
         oLINE_CNT <= '0;
      end else begin
         if (line_end) begin
            oLINE_LEN <= x;
            x         <= '0;
         end else if (blank_r && x != '1) begin
            x <= x + 11'd1;
         end
         // a line end coinciding with frame start still belongs to the finished frame
         if (frame_start) begin
            oLINE_CNT <= line_end ? line_cnt_inc : line_cnt;
            line_cnt  <= '0;
         end else if (line_end) begin
            line_cnt <= line_cnt_inc;
         end
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:       if (arm_r) state_next = WAIT_FRAME;
         WAIT_FRAME: if (frame_start) state_next = CAPTURE;
         CAPTURE: begin
            if (err_hit)        state_next = IDLE;
            else if (last_line) state_next = DONE;
         end
         DONE:       state_next = IDLE;
         default:    state_next = IDLE;
      endcase
   end

   always_comb begin
      oBUSY     = (state == WAIT_FRAME) || (state == CAPTURE);
      oDONE     = (state == DONE);
      arm_clear = (state == IDLE) && arm_r;
      write_hit = (state == CAPTURE) && blank_r && (x < H_LEN);
      err_hit   = (state == CAPTURE) &&
                  ((line_end && x != H_LEN) || (frame_start && !last_line));
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oWR_EN   <= 1'b0;
         oWR_ADDR <= '0;
         oWR_DATA <= '0;
         addr     <= '0;
         oERR     <= 1'b0;
      end else begin
         oWR_EN <= write_hit;
         if (arm_clear) begin
            addr     <= '0;
            oWR_ADDR <= '0;
         end else if (write_hit) begin
            oWR_ADDR <= addr;
            oWR_DATA <= pix_r;
            addr     <= addr + 1'b1;
         end
         if (arm_clear)    oERR <= 1'b0;
         else if (err_hit) oERR <= 1'b1;
      end
   end

`ifdef CAPTURE_CHECKSUM_EN
   logic [31:0] sum;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n)        sum <= '0;
      else if (arm_clear) sum <= '0;
      else if (write_hit) sum <= sum + {8'd0, pix_r};
   end

   assign oCHECKSUM = sum;
`else
   assign oCHECKSUM = '0;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture on a reduced 8x6 raster.
module tb_vga_frame_capture;

   localparam int H  = 8;
   localparam int V  = 6;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hs = 1'b1, vs = 1'b1, bl = 1'b0, arm = 1'b0;
   logic [7:0]    b = '0, g = '0, r = '0;
   logic          busy, done, err, wr_en;
   logic [AW-1:0] wr_addr;
   logic [23:0]   wr_data;
   logic [10:0]   line_len;
   logic [9:0]    line_cnt;
   logic [31:0]   checksum;

   vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .iVGA_CLK(clk), .iRST_n(rst_n), .iHS(hs), .iVS(vs), .iBLANK_n(bl),
      .iB(b), .iG(g), .iR(r), .iARM(arm),
      .oBUSY(busy), .oDONE(done), .oERR(err), .oWR_EN(wr_en),
      .oWR_ADDR(wr_addr), .oWR_DATA(wr_data), .oLINE_LEN(line_len),
      .oLINE_CNT(line_cnt), .oCHECKSUM(checksum)
   );

   always #5 clk = ~clk;

   typedef logic [AW+23:0] exp_t;
   exp_t        q[$];
   int          errors = 0, checks = 0, done_cnt = 0, exp_addr = 0, frame_id = 0;
   logic [31:0] exp_sum = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", wr_addr, wr_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               errors++;
               $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                        wr_addr, wr_data, e[AW+23:24], e[23:0]);
            end
         end
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic drive(input logic v, input logic h, input logic blank,
                        input logic [23:0] px, input logic a);
      @(negedge clk);
      vs = v; hs = h; bl = blank; {b, g, r} = px; arm = a;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
   endtask

   task automatic pulse_arm();
      drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
   endtask

   // 2 vsync lines, 1 back-porch line, n_lines active lines, fp front-porch lines
   task automatic send_frame(input int n_lines, input int fp, input bit cap, input int bad_line,
                             input int bad_len, input int arm_line, input int rst_pix);
      bit          capturing;
      int          len;
      logic [23:0] px;
      capturing = cap;
      frame_id++;
      for (int l = 0; l < 2; l++)
         for (int i = 0; i < H + 4; i++) drive(1'b0, i >= 2, 1'b0, '0, 1'b0);
      for (int i = 0; i < H + 4; i++) drive(1'b1, i >= 2, 1'b0, '0, 1'b0);
      for (int l = 0; l < n_lines; l++) begin
         len = (l == bad_line) ? bad_len : H;
         for (int i = 0; i < 4; i++) drive(1'b1, i >= 2, 1'b0, '0, (l == arm_line) && (i == 0));
         for (int x = 0; x < len; x++) begin
            px = {8'(frame_id), 8'(l), 8'(x)};
            if (capturing && x < H && exp_addr == rst_pix) begin
               @(negedge clk);
               #1 rst_n = 1'b0;
               #1;
               check("rst_wr_en", 32'(wr_en), 0);
               check("rst_busy", 32'(busy), 0);
               check("rst_wr_addr", 32'(wr_addr), 0);
               q.delete();
               capturing = 1'b0;
               drive(1'b1, 1'b1, 1'b1, px, 1'b0);
               rst_n = 1'b1;
            end else begin
               drive(1'b1, 1'b1, 1'b1, px, 1'b0);
               if (capturing && x < H) begin
                  q.push_back({AW'(exp_addr), px});
                  exp_addr++;
                  exp_sum += 32'(px);
               end
            end
         end
         if (l == bad_line) capturing = 1'b0;
      end
      for (int l = 0; l < fp; l++)
         for (int i = 0; i < H + 4; i++) drive(1'b1, i >= 2, 1'b0, '0, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_wr_en", 32'(wr_en), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_err", 32'(err), 0);
      check("reset_wr_addr", 32'(wr_addr), 0);
      check("reset_wr_data", 32'(wr_data), 0);
      check("reset_line_len", 32'(line_len), 0);
      check("reset_line_cnt", 32'(line_cnt), 0);
      check("reset_checksum", checksum, 0);
      rst_n = 1'b1;
      idle(5);

      // free-running measurement without arm
      send_frame(V, 1, 1'b0, -1, 0, -1, -1);
      send_frame(V, 1, 1'b0, -1, 0, -1, -1);
      check("idle_line_len", 32'(line_len), H);
      check("idle_line_cnt", 32'(line_cnt), V);
      check("idle_busy", 32'(busy), 0);
      check("idle_done_cnt", done_cnt, 0);

      // arm mid-frame; arm again during capture; next VS coincides with final line end
      exp_addr = 0; exp_sum = '0;
      send_frame(V, 1, 1'b0, -1, 0, 2, -1);
      check("armed_busy", 32'(busy), 1);
      send_frame(V, 0, 1'b1, -1, 0, 3, -1);
      send_frame(V, 1, 1'b0, -1, 0, -1, -1);
      check("cap_done_cnt", done_cnt, 1);
      check("cap_busy", 32'(busy), 0);
      check("cap_err", 32'(err), 0);
      check("cap_last_addr", 32'(wr_addr), H * V - 1);
      check("cap_queue_empty", q.size(), 0);
      check("cap_line_cnt", 32'(line_cnt), V);
`ifdef CAPTURE_CHECKSUM_EN
      check("cap_checksum", checksum, exp_sum);
`else
      check("cap_checksum", checksum, 0);
`endif

      // short final line
      exp_addr = 0; exp_sum = '0;
      pulse_arm();
      send_frame(V, 1, 1'b1, V - 1, H - 1, -1, -1);
      check("short_err", 32'(err), 1);
      check("short_done_cnt", done_cnt, 1);
      check("short_line_len", 32'(line_len), H - 1);
      check("short_busy", 32'(busy), 0);
      check("short_last_addr", 32'(wr_addr), H * V - 2);
      check("short_queue_empty", q.size(), 0);

      // arm clears the sticky error; then a long line
      exp_addr = 0;
      pulse_arm();
      idle(2);
      check("rearm_err_clear", 32'(err), 0);
      check("rearm_busy", 32'(busy), 1);
      send_frame(V, 1, 1'b1, 2, H + 2, -1, -1);
      check("long_err", 32'(err), 1);
      check("long_last_addr", 32'(wr_addr), 3 * H - 1);
      check("long_done_cnt", done_cnt, 1);
      check("long_queue_empty", q.size(), 0);

      // premature frame start after 3 lines
      exp_addr = 0;
      pulse_arm();
      idle(2);
      check("early_err_clear", 32'(err), 0);
      send_frame(3, 1, 1'b1, -1, 0, -1, -1);
      check("early_still_busy", 32'(busy), 1);
      send_frame(V, 1, 1'b0, -1, 0, -1, -1);
      check("early_err", 32'(err), 1);
      check("early_busy", 32'(busy), 0);
      check("early_last_addr", 32'(wr_addr), 3 * H - 1);
      check("early_done_cnt", done_cnt, 1);

      // reset at write address 20, then no writes without arm
      exp_addr = 0;
      pulse_arm();
      send_frame(V, 1, 1'b1, -1, 0, -1, 20);
      send_frame(V, 1, 1'b0, -1, 0, -1, -1);
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_err", 32'(err), 0);
      check("post_rst_done_cnt", done_cnt, 1);
      check("post_rst_queue_empty", q.size(), 0);

      idle(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
